dmem_responder: RTL and testbench

- Memory-side responder for the processor's data-memory port, with a valid/ready request channel and a valid/ready response channel.
- Serves word loads and byte-enabled stores after a configurable wait-state latency.
- Flags misaligned or out-of-range accesses.
- Replaces the zero-latency data memory when the core moves to a multi-cycle/stalling memory interface.

---
 rtl/dmem_responder_pkg.sv | 13 +
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_responder_pkg;

    localparam int WORD_SIZE = 32;
    localparam int BE_W      = WORD_SIZE / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and an asynchronous read port.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     idx,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [BE_W-1:0]      be,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one outstanding access, valid/ready on both channels,
// error response for misaligned or out-of-window addresses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic            accept;
    logic            enter_resp;

    logic            lat_write;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic [BE_W-1:0] lat_be;

    logic            acc_write;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic [BE_W-1:0] acc_be;
    logic [31:0]     acc_off;
    logic            acc_ok;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]     arr_rdata;
    logic            arr_we;

    assign accept     = req_valid & req_ready;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    // With no wait states the access happens on the accept edge, before the latch is loaded.
    assign acc_write = (state == IDLE) ? req_write : lat_write;
    assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign acc_be    = (state == IDLE) ? req_be    : lat_be;

    // 33-bit span compare keeps the window check from wrapping near the top of the address space.
    assign acc_off = acc_addr - BASE_ADDR;
    assign acc_ok  = (acc_addr[1:0] == 2'b00) && (acc_addr >= BASE_ADDR) && ({1'b0, acc_off} < SPAN);
    assign acc_idx = acc_off[IDX_W+1:2];
    assign arr_we  = enter_resp & acc_write & acc_ok & ~reset;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .idx  (acc_idx),
        .wdata(acc_wdata),
        .be   (acc_be),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (state == IDLE && accept) begin
            cnt <= CNT_INIT;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // Response data is captured once on entry to RESP and held through backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_rdata <= (acc_ok && !acc_write) ? arr_rdata : 32'd0;
            rsp_err   <= ~acc_ok;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against an address-map reference model.
module tb_dmem_responder;

    localparam int          W_MAIN = 2;
    localparam logic [31:0] BASE0  = 32'hFFFF_FC00;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0 = 1'b0, req_ready0, req_write0 = 1'b0;
    logic [31:0] req_addr0 = 32'd0, req_wdata0 = 32'd0;
    logic [3:0]  req_be0 = 4'd0;
    logic        rsp_valid0, rsp_err0;
    logic        rsp_ready0 = 1'b1;
    logic [31:0] rsp_rdata0;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W_MAIN), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(BASE0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    int checks = 0;
    int passes = 0;
    logic [31:0] mem_m  [256];
    logic [31:0] mem0_m [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit in_map(input logic [31:0] base, input logic [31:0] a);
        longint unsigned la = 64'(a);
        longint unsigned lb = 64'(base);
        return (a[1:0] == 2'b00) && (la >= lb) && (la < lb + 64'd1024);
    endfunction

    // Reference: a word array addressed relative to the base; stores merge enabled bytes.
    task automatic model(input bit sel, input logic [31:0] base, input bit w,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         output logic [31:0] rd, output logic e);
        int idx;
        rd = 32'd0;
        e  = !in_map(base, a);
        if (!e) begin
            idx = int'((a - base) >> 2);
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        if (sel) mem0_m[idx][8*b +: 8] = wd[8*b +: 8];
                        else     mem_m[idx][8*b +: 8]  = wd[8*b +: 8];
                    end
                end
            end else begin
                rd = sel ? mem0_m[idx] : mem_m[idx];
            end
        end
    endtask

    task automatic resp_check(input bit w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input string tag, output logic [31:0] rd_obs);
        logic [31:0] erd;
        logic        ee;
        int          k = 1;
        @(negedge clk);
        while (!rsp_valid && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        model(1'b0, 32'h0, w, a, wd, be, erd, ee);
        chk({tag, " latency"}, 32'(k), 32'(1 + W_MAIN));
        chk({tag, " rdata"}, rsp_rdata, erd);
        chk({tag, " err"}, 32'(rsp_err), 32'(ee));
        rd_obs = rsp_rdata;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        int g = 0;
        @(negedge clk);
        while (!req_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) chk("req_ready timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_be = 4'($urandom);
    endtask

    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input string tag, output logic [31:0] rd_obs);
        issue(w, a, wd, be);
        resp_check(w, a, wd, be, tag, rd_obs);
    endtask

    logic [31:0] rd, erd;
    logic        ee;
    bit          s_w[12];
    logic [31:0] s_a[12], s_d[12];
    logic [3:0]  s_b[12];

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset req_ready0", 32'(req_ready0), 32'd1);
        reset = 1'b0;

        // Fill every word so later loads never depend on power-up contents
        for (int i = 0; i < 256; i++) begin
            txn(1'b1, 32'(i) << 2, $urandom, 4'hF, "prefill", rd);
        end

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "store 0x10", rd);
        txn(1'b0, 32'h10, 32'h0, 4'h0, "load 0x10", rd);
        chk("load 0x10 value", rd, 32'hDEAD_BEEF);

        txn(1'b1, 32'h20, 32'h1122_3344, 4'hF, "store 0x20", rd);
        txn(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, "store 0x20 be", rd);
        txn(1'b0, 32'h20, 32'h0, 4'h0, "load 0x20", rd);
        chk("byte enable merge", rd, 32'h11BB_33DD);

        txn(1'b0, 32'h22, 32'h0, 4'h0, "load misaligned", rd);
        txn(1'b1, 32'h400, 32'h9999_9999, 4'hF, "store out of range", rd);
        txn(1'b0, 32'h0, 32'h0, 4'h0, "load 0x0 after oor", rd);
        txn(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF, "store top of space", rd);
        txn(1'b1, 32'h24, 32'hFFFF_FFFF, 4'h0, "store be zero", rd);
        txn(1'b0, 32'h24, 32'h0, 4'h0, "load after be zero", rd);

        // Backpressure: a queued request must wait until the cycle after the handshake
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        begin
            int k = 1;
            @(negedge clk);
            while (!rsp_valid && k < 40) begin
                @(posedge clk);
                k++;
                @(negedge clk);
            end
            chk("bp latency", 32'(k), 32'(1 + W_MAIN));
        end
        model(1'b0, 32'h0, 1'b0, 32'h20, 32'h0, 4'h0, erd, ee);
        for (int c = 0; c < 5; c++) begin
            chk("bp rsp_valid held", 32'(rsp_valid), 32'd1);
            chk("bp rsp_rdata held", rsp_rdata, erd);
            chk("bp req_ready low", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp not accepted at handshake", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        resp_check(1'b0, 32'h10, 32'h0, 4'h0, "bp queued load", rd);

        // Reset while a store is still waiting: it is dropped
        issue(1'b1, 32'h30, 32'h55AA_55AA, 4'hF);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid reset req_ready", 32'(req_ready), 32'd1);
        chk("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid reset rsp_rdata", rsp_rdata, 32'd0);
        txn(1'b0, 32'h30, 32'h0, 4'h0, "load 0x30 after reset", rd);

        // Reset in RESP: the store was committed on entry and must persist
        issue(1'b1, 32'h34, 32'h1357_2468, 4'hF);
        begin
            int k = 1;
            @(negedge clk);
            while (!rsp_valid && k < 40) begin
                @(posedge clk);
                k++;
                @(negedge clk);
            end
            chk("resp reset latency", 32'(k), 32'(1 + W_MAIN));
        end
        model(1'b0, 32'h0, 1'b1, 32'h34, 32'h1357_2468, 4'hF, erd, ee);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("resp reset rsp_valid", 32'(rsp_valid), 32'd0);
        txn(1'b0, 32'h34, 32'h0, 4'h0, "load 0x34 after reset", rd);

        // Random mix of loads, stores and bad addresses
        for (int i = 0; i < 400; i++) begin
            int          r = int'($urandom_range(0, 9));
            logic [31:0] a;
            if (r < 7)       a = 32'($urandom_range(0, 255)) << 2;
            else if (r == 7) a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
            else             a = $urandom;
            txn(1'($urandom), a, $urandom, 4'($urandom), "random", rd);
        end

        // Zero-wait instance near the top of the address space, back-to-back requests
        s_w = '{1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0};
        s_a = '{BASE0, BASE0 + 32'h3FC, BASE0, BASE0 + 32'h3FC, BASE0, BASE0, 32'h0,
                32'hFFFF_FBFC, BASE0 + 32'h2, BASE0, BASE0, 32'h0000_0400};
        s_d = '{32'hCAFE_F00D, 32'h0BAD_C0DE, 0, 0, 32'h1111_1111, 0, 0, 0,
                32'h7777_7777, 32'hFFFF_FFFF, 0, 0};
        s_b = '{4'hF, 4'hF, 4'h0, 4'h0, 4'b0110, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
        req_valid0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("b2b req_ready", 32'(req_ready0), 32'd1);
            req_write0 = s_w[i]; req_addr0 = s_a[i]; req_wdata0 = s_d[i]; req_be0 = s_b[i];
            @(posedge clk);
            @(negedge clk);
            model(1'b1, BASE0, s_w[i], s_a[i], s_d[i], s_b[i], erd, ee);
            chk("b2b rsp_valid", 32'(rsp_valid0), 32'd1);
            chk("b2b rdata", rsp_rdata0, erd);
            chk("b2b err", 32'(rsp_err0), 32'(ee));
            chk("b2b busy", 32'(req_ready0), 32'd0);
        end
        @(negedge clk);
        req_valid0 = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
